// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: access sizes, read/write, FSM states and grant owner.
package ram_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Both 10 and 11 mean word on the request side; the RAM only ever sees 10.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_BYTE || size == SIZE_HALF) ? size : SIZE_WORD;
    endfunction

endpackage

// File: rtl/ram_req_check.sv
// Combinational legality check for one RAM access: alignment (optional) and
// address range (the last byte touched must stay inside the RAM).
module ram_req_check
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter bit CHECK_ALIGN = 1'b1
)(
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    output logic              legal
);

    logic [ADDR_W:0] span;
    logic [ADDR_W:0] last_byte;
    logic            aligned;

    always_comb begin
        span    = '0;
        aligned = 1'b1;
        case (size)
            SIZE_BYTE: begin
                span    = (ADDR_W+1)'(0);
                aligned = 1'b1;
            end
            SIZE_HALF: begin
                span    = (ADDR_W+1)'(1);
                aligned = ~addr[0];
            end
            default: begin
                span    = (ADDR_W+1)'(3);
                aligned = (addr[1:0] == 2'b00);
            end
        endcase
        // A carry into the extra top bit means the access runs off the end of the RAM.
        last_byte = {1'b0, addr} + span;
        legal     = ~last_byte[ADDR_W] & (aligned | ~CHECK_ALIGN);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-addressed RAM between an instruction-fetch
// port (word reads) and a data port (byte/half/word reads and writes).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1,
    parameter bit CHECK_ALIGN = 1'b1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic              d_se,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic              ram_rw,
    output logic              ram_se,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    // Handshake: a requester raises req with its inputs stable and holds both until
    // it sees a one-cycle ack; rdata/err are valid only in that ack cycle.
    state_t            state;
    state_t            state_nx;
    grant_t            grant_q;
    grant_t            last_grant;
    grant_t            grant_nx;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              any_req;
    logic              access_done;
    logic              chk_legal;
    logic [1:0]        chk_size;
    logic [ADDR_W-1:0] chk_addr;

    // On a tie the port that was not served last wins, so neither can starve.
    always_comb begin
        any_req = i_req | d_req;
        if (i_req && d_req) begin
            grant_nx = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            grant_nx = GRANT_D;
        end else begin
            grant_nx = GRANT_I;
        end
        chk_size = (grant_nx == GRANT_D) ? norm_size(d_size) : SIZE_WORD;
        chk_addr = (grant_nx == GRANT_D) ? d_addr : i_addr;
    end

    ram_req_check #(
        .ADDR_W      (ADDR_W),
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_check (
        .size  (chk_size),
        .addr  (chk_addr),
        .legal (chk_legal)
    );

    assign access_done = (wait_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx = chk_legal ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (access_done) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // RAM control is registered at grant time and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= GRANT_I;
            last_grant <= GRANT_D;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ram_rw     <= RW_READ;
            ram_se     <= 1'b0;
            ram_size   <= SIZE_BYTE;
            ram_addr   <= '0;
            ram_din    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q    <= grant_nx;
                        last_grant <= grant_nx;
                        err_q      <= ~chk_legal;
                        rdata_q    <= '0;
                        wait_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        if (grant_nx == GRANT_D) begin
                            ram_rw   <= d_rw;
                            ram_size <= norm_size(d_size);
                            ram_se   <= d_se;
                            ram_addr <= d_addr;
                            ram_din  <= d_wdata;
                        end else begin
                            ram_rw   <= RW_READ;
                            ram_size <= SIZE_WORD;
                            ram_se   <= 1'b0;
                            ram_addr <= i_addr;
                            ram_din  <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        if (ram_rw == RW_READ) begin
                            rdata_q <= ram_dout;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_en  = (state == ST_ACCESS);
        i_ack   = (state == ST_RESP) && (grant_q == GRANT_I);
        d_ack   = (state == ST_RESP) && (grant_q == GRANT_D);
        i_rdata = i_ack ? rdata_q : '0;
        d_rdata = d_ack ? rdata_q : '0;
        i_err   = i_ack & err_q;
        d_err   = d_ack & err_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: byte-level RAM, transaction-level model of
// arbitration/latency/data, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req, i_ack, i_err, d_req, d_rw, d_se, d_ack, d_err;
    logic [8:0]  i_addr, d_addr, ram_addr;
    logic [1:0]  d_size, ram_size;
    logic [31:0] i_rdata, d_wdata, d_rdata, ram_din, ram_dout;
    logic        ram_en, ram_rw, ram_se;

    logic        n_d_req, n_d_rw, n_d_se, n_i_ack, n_i_err, n_d_ack, n_d_err;
    logic        n_ram_en, n_ram_rw, n_ram_se;
    logic [8:0]  n_d_addr, n_ram_addr;
    logic [1:0]  n_d_size, n_ram_size;
    logic [31:0] n_d_wdata, n_i_rdata, n_d_rdata, n_ram_din;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;
    int          last_grant = 2;
    logic [7:0]  ram_mem [512];
    logic [7:0]  mdl_mem [512];
    int          exp_ack_port [int];
    bit          exp_en [int];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.ADDR_W(9), .WAIT_CYCLES(WAIT), .CHECK_ALIGN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_se(d_se), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_se(ram_se), .ram_size(ram_size),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_arbiter #(.ADDR_W(9), .WAIT_CYCLES(WAIT), .CHECK_ALIGN(1'b0)) u_noalign (
        .clk(clk), .reset(reset),
        .i_req(1'b0), .i_addr(9'h000), .i_ack(n_i_ack), .i_rdata(n_i_rdata), .i_err(n_i_err),
        .d_req(n_d_req), .d_rw(n_d_rw), .d_size(n_d_size), .d_se(n_d_se), .d_addr(n_d_addr),
        .d_wdata(n_d_wdata), .d_ack(n_d_ack), .d_rdata(n_d_rdata), .d_err(n_d_err),
        .ram_en(n_ram_en), .ram_rw(n_ram_rw), .ram_se(n_ram_se), .ram_size(n_ram_size),
        .ram_addr(n_ram_addr), .ram_din(n_ram_din), .ram_dout(32'hCAFE_F00D)
    );

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // RAM: combinational read with the RAM's own sign extension, write on the clock edge.
    always_comb begin
        ram_dout = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < nbytes(ram_size)) ram_dout[8*b +: 8] = ram_mem[(int'(ram_addr) + b) & 511];
        end
        if (ram_se && ram_size == 2'b00 && ram_dout[7])  ram_dout[31:8]  = '1;
        if (ram_se && ram_size == 2'b01 && ram_dout[15]) ram_dout[31:16] = '1;
    end

    always @(posedge clk) begin
        if (ram_en && ram_rw) begin
            for (int b = 0; b < nbytes(ram_size); b++)
                ram_mem[(int'(ram_addr) + b) & 511] <= ram_din[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transaction seen in an idle cycle t is acked at t+WAIT+1 (legal) or t+1.
    function automatic int plan(input int port, input bit rw, input logic [1:0] size, input bit se,
                                input int addr, input logic [31:0] wdata, input int t);
        int          nb;
        int          ack;
        bit          legal;
        logic [31:0] data;
        nb    = nbytes(size);
        legal = (addr + nb - 1 <= 511) && (addr % nb == 0);
        data  = '0;
        if (legal) begin
            for (int k = t + 1; k <= t + WAIT; k++) exp_en[k] = 1'b1;
            ack = t + WAIT + 1;
            if (rw) begin
                for (int b = 0; b < nb; b++) mdl_mem[addr + b] = wdata[8*b +: 8];
            end else begin
                for (int b = 0; b < nb; b++) data[8*b +: 8] = mdl_mem[addr + b];
                if (se && nb == 1 && data[7])  data[31:8]  = '1;
                if (se && nb == 2 && data[15]) data[31:16] = '1;
            end
        end else begin
            ack = t + 1;
        end
        exp_ack_port[ack] = port;
        exp_q.push_back({!legal, data});
        last_grant = port;
        return ack;
    endfunction

    always @(negedge clk) begin
        logic [32:0] p;
        bit          ei;
        bit          ed;
        if (chk_on && !reset) begin
            ei = exp_ack_port.exists(cyc) && exp_ack_port[cyc] == 1;
            ed = exp_ack_port.exists(cyc) && exp_ack_port[cyc] == 2;
            chk("i_ack", 32'(i_ack), 32'(ei));
            chk("d_ack", 32'(d_ack), 32'(ed));
            chk("ram_en", 32'(ram_en), 32'(exp_en.exists(cyc)));
            chk("ram_size_not_11", 32'(ram_size == 2'b11), 32'd0);
            if (i_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    p = exp_q.pop_front();
                    chk(i_ack ? "i_rdata" : "d_rdata", i_ack ? i_rdata : d_rdata, p[31:0]);
                    chk(i_ack ? "i_err" : "d_err", 32'(i_ack ? i_err : d_err), 32'(p[32]));
                end
            end
        end
    end

    task automatic drive(input int port, input bit rw, input logic [1:0] size, input bit se,
                         input int addr, input logic [31:0] wdata);
        if (port == 1) begin
            i_req  = 1'b1;
            i_addr = 9'(addr);
        end else begin
            d_req   = 1'b1;
            d_rw    = rw;
            d_size  = size;
            d_se    = se;
            d_addr  = 9'(addr);
            d_wdata = wdata;
        end
    endtask

    task automatic run_one(input int port, input bit rw, input logic [1:0] size, input bit se,
                           input int addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat);
        int t;
        bit got;
        @(negedge clk);
        t = cyc;
        drive(port, rw, size, se, addr, wdata);
        if (port == 1) void'(plan(1, 1'b0, 2'b10, 1'b0, addr, 32'h0, t));
        else           void'(plan(2, rw, size, se, addr, wdata, t));
        got = 1'b0; rd = '0; er = 1'b0; lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if ((port == 1 && i_ack) || (port == 2 && d_ack)) begin
                got = 1'b1;
                lat = cyc - t;
                rd  = (port == 1) ? i_rdata : d_rdata;
                er  = (port == 1) ? i_err : d_err;
                break;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        if (port == 1) i_req = 1'b0; else d_req = 1'b0;
    endtask

    // Both ports request in the same cycle; I reads a word, D performs a read.
    task automatic run_dual(input int ia, input logic [1:0] dsize, input bit dse, input int da,
                            output int i_c, output int d_c);
        int t;
        int first;
        int a1;
        @(negedge clk);
        t = cyc;
        drive(1, 1'b0, 2'b10, 1'b0, ia, 32'h0);
        drive(2, 1'b0, dsize, dse, da, 32'h0);
        first = (last_grant == 1) ? 2 : 1;
        if (first == 1) begin
            a1 = plan(1, 1'b0, 2'b10, 1'b0, ia, 32'h0, t);
            void'(plan(2, 1'b0, dsize, dse, da, 32'h0, a1 + 1));
        end else begin
            a1 = plan(2, 1'b0, dsize, dse, da, 32'h0, t);
            void'(plan(1, 1'b0, 2'b10, 1'b0, ia, 32'h0, a1 + 1));
        end
        i_c = -1; d_c = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (i_req && i_ack) begin i_c = cyc; i_req = 1'b0; end
            if (d_req && d_ack) begin d_c = cyc; d_req = 1'b0; end
            if (!i_req && !d_req) break;
        end
        if (i_req || d_req) chk("dual_timeout", 32'd0, 32'd1);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          ic;
        int          dc;
        int          t;

        for (int a = 0; a < 512; a++) begin
            mdl_mem[a] = 8'((a * 37 + 11) & 255);
        end
        {mdl_mem[16'h013], mdl_mem[16'h012], mdl_mem[16'h011], mdl_mem[16'h010]} = 32'h11223344;
        {mdl_mem[16'h1FF], mdl_mem[16'h1FE], mdl_mem[16'h1FD], mdl_mem[16'h1FC]} = 32'hEFBEADDE;
        for (int a = 0; a < 512; a++) ram_mem[a] <= mdl_mem[a];

        i_req = 0; i_addr = 0; d_req = 0; d_rw = 0; d_size = 0; d_se = 0; d_addr = 0; d_wdata = 0;
        n_d_req = 0; n_d_rw = 0; n_d_size = 0; n_d_se = 0; n_d_addr = 0; n_d_wdata = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(|{i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, ram_en, ram_rw,
                                   ram_se, ram_size, ram_addr, ram_din}), 32'd0);
        chk("reset_state", 32'(u_dut.state), 32'(ST_IDLE));
        reset  = 1'b0;
        chk_on = 1'b1;

        run_dual(16'h010, 2'b10, 1'b0, 16'h020, ic, dc);
        chk("dual_i_first", 32'(ic < dc), 32'd1);
        chk("dual_gap", 32'(dc - ic), 32'd3);

        run_one(1, 1'b0, 2'b10, 1'b0, 16'h010, 32'h0, rd, er, lat);
        chk("i_fetch_data", rd, 32'h11223344);
        chk("i_fetch_err", 32'(er), 32'd0);
        chk("i_fetch_lat", 32'(lat), 32'd2);

        run_one(2, 1'b1, 2'b00, 1'b0, 16'h005, 32'h0000_0080, rd, er, lat);
        chk("d_wbyte_rdata", rd, 32'h0);
        chk("d_wbyte_lat", 32'(lat), 32'd2);
        run_one(2, 1'b0, 2'b00, 1'b1, 16'h005, 32'h0, rd, er, lat);
        chk("d_rbyte_se1", rd, 32'hFFFF_FF80);
        run_one(2, 1'b0, 2'b00, 1'b0, 16'h005, 32'h0, rd, er, lat);
        chk("d_rbyte_se0", rd, 32'h0000_0080);

        run_one(2, 1'b0, 2'b01, 1'b0, 16'h003, 32'h0, rd, er, lat);
        chk("d_half_misalign_err", 32'(er), 32'd1);
        chk("d_half_misalign_data", rd, 32'h0);
        chk("d_half_misalign_lat", 32'(lat), 32'd1);

        run_one(2, 1'b0, 2'b10, 1'b0, 16'h1FC, 32'h0, rd, er, lat);
        chk("d_word_top_data", rd, 32'hEFBE_ADDE);
        chk("d_word_top_err", 32'(er), 32'd0);

        run_one(2, 1'b1, 2'b11, 1'b0, 16'h040, 32'hA5A5_5A5A, rd, er, lat);
        run_one(2, 1'b0, 2'b10, 1'b0, 16'h040, 32'h0, rd, er, lat);
        chk("d_word_wr_rd", rd, 32'hA5A5_5A5A);

        run_one(2, 1'b1, 2'b01, 1'b0, 16'h00C, 32'h1234_ABCD, rd, er, lat);
        run_one(2, 1'b0, 2'b01, 1'b1, 16'h00C, 32'h0, rd, er, lat);
        chk("d_half_se1", rd, 32'hFFFF_ABCD);
        run_one(2, 1'b0, 2'b01, 1'b0, 16'h00E, 32'h0, rd, er, lat);
        run_one(2, 1'b0, 2'b10, 1'b0, 16'h00C, 32'h0, rd, er, lat);

        run_one(1, 1'b0, 2'b10, 1'b0, 16'h012, 32'h0, rd, er, lat);
        chk("i_misalign_err", 32'(er), 32'd1);
        chk("i_misalign_lat", 32'(lat), 32'd1);
        run_one(2, 1'b0, 2'b10, 1'b0, 16'h1FE, 32'h0, rd, er, lat);
        chk("d_word_1fe_err", 32'(er), 32'd1);

        run_one(1, 1'b0, 2'b10, 1'b0, 16'h030, 32'h0, rd, er, lat);
        run_dual(16'h034, 2'b00, 1'b1, 16'h041, ic, dc);
        chk("tie_goes_to_d", 32'(dc < ic), 32'd1);
        chk("tie_gap", 32'(ic - dc), 32'd3);

        // Reset in the middle of a data write: the access is dropped without an ack.
        @(negedge clk);
        chk_on = 1'b0;
        drive(2, 1'b1, 2'b10, 1'b0, 16'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("abort_in_access", 32'(ram_en), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'(|{i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, ram_en, ram_rw,
                                   ram_se, ram_size, ram_addr, ram_din}), 32'd0);
        chk("abort_state", 32'(u_dut.state), 32'(ST_IDLE));
        reset = 1'b0;
        d_req = 1'b0;
        last_grant = 2;
        @(negedge clk);
        chk("abort_no_ack", 32'(d_ack), 32'd0);
        chk("abort_no_en", 32'(ram_en), 32'd0);
        chk_on = 1'b1;
        run_one(2, 1'b0, 2'b10, 1'b0, 16'h010, 32'h0, rd, er, lat);
        chk("after_abort_read", rd, 32'h11223344);

        // Alignment check disabled: range still enforced, misaligned in-range word is legal.
        @(negedge clk);
        n_d_req = 1'b1; n_d_rw = 1'b0; n_d_size = 2'b10; n_d_addr = 9'h1FE;
        @(negedge clk);
        chk("na_range_ack", 32'(n_d_ack), 32'd1);
        chk("na_range_err", 32'(n_d_err), 32'd1);
        chk("na_range_no_en", 32'(n_ram_en), 32'd0);
        n_d_req = 1'b0;
        @(negedge clk);
        n_d_req = 1'b1; n_d_addr = 9'h1FB;
        @(negedge clk);
        chk("na_misalign_en", 32'(n_ram_en), 32'd1);
        chk("na_misalign_addr", 32'(n_ram_addr), 32'h1FB);
        @(negedge clk);
        chk("na_misalign_ack", 32'(n_d_ack), 32'd1);
        chk("na_misalign_err", 32'(n_d_err), 32'd0);
        chk("na_misalign_data", n_d_rdata, 32'hCAFE_F00D);
        n_d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
